rx_conn_filter: RTL and testbench
=================================

RX_CONN_FILTER -- requirements
Module: rx_conn_filter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RX/TX stream word width in bits.
REQ-002 SHALL have parameter KEY_WORD, default 3, 0-based word index within a packet that carries the 32-bit lookup key (the key is word bits [31:0]).
REQ-003 SHALL have parameter MAX_WORDS, default 64, power of two, packet buffer depth in words.
REQ-004 SHALL have parameter RESP_WIDTH, default 18, connection ID width.
REQ-005 SHALL have ports:
 clk  in  1  sole clock, rising edge.
 rst_n  in  1  reset, asynchronous, active-low.
 s_axis_rx_tvalid / tdata / tlast  in  1 / DATA_WIDTH / 1  ingress packet stream.
 s_axis_rx_tready  out  1  ingress ready.
 m_axis_lookup_valid / key  out  1 / 32  lookup request to connection manager.
 m_axis_lookup_ready  in  1  request accepted.
 s_axis_lookup_valid / hit / resp  in  1 / 1 / RESP_WIDTH  lookup response.
 s_axis_lookup_ready  out  1  constant 1.
 m_axis_tx_tvalid / tdata / tlast  out  1 / DATA_WIDTH / 1  egress stream.
 m_axis_tx_tuser  out  RESP_WIDTH  connection ID, constant for the whole packet.
 m_axis_tx_tready  in  1  egress ready.
 fwd_count, drop_count  out  16 each  statistics.

Function
REQ-006 SHALL hold one packet in flight at a time, store-and-forward.
REQ-007 SHALL implement states IDLE, RECV, WAIT_RESP, FORWARD, FLUSH, DISCARD.
REQ-008 SHALL assert s_axis_rx_tready in IDLE, RECV and DISCARD only; word accepted = tvalid & tready.
REQ-009 IDLE->RECV on the first accepted word; words are written to the buffer in arrival order.
REQ-010 On acceptance of word KEY_WORD, SHALL assert m_axis_lookup_valid with key = word[31:0] on the next cycle and hold both until m_axis_lookup_ready.
REQ-011 SHALL latch hit and resp on s_axis_lookup_valid only while a request is outstanding; responses arriving with no outstanding request SHALL be ignored.
REQ-012 The decision point is the later of tlast acceptance and response latch; tlast first -> WAIT_RESP.
REQ-013 At the decision point: hit=1 -> FORWARD next cycle; hit=0 -> FLUSH next cycle.
REQ-014 Runt: if tlast is accepted before word KEY_WORD, SHALL issue no lookup and go to FLUSH.
REQ-015 Oversize: a word arriving while the buffer holds MAX_WORDS words SHALL be accepted and discarded, state -> DISCARD; DISCARD consumes until tlast, then waits for any outstanding response, then FLUSH.
REQ-016 FORWARD: one-cycle buffer read latency; m_axis_tx_tvalid first asserted 2 cycles after the decision point; tdata, tlast and tuser SHALL be held stable while tvalid=1 and tready=0.
REQ-017 After the tlast word is accepted downstream, SHALL go to IDLE and increment fwd_count.
REQ-018 FLUSH lasts one cycle, empties the buffer, increments drop_count and goes to IDLE.
REQ-019 Counters SHALL saturate at 0xFFFF.

Reset
REQ-020 While rst_n=0, outputs SHALL be zero (except s_axis_lookup_ready=1), state IDLE, buffer empty, no request outstanding.
REQ-021 Reset asserted mid-packet SHALL discard the partial packet without a tx or counter update; the first packet after release SHALL be processed normally.

Configuration
REQ-022 Macro RX_FILTER_STATS_EN defined: fwd_count and drop_count SHALL count per REQ-017/018/019.
REQ-023 Macro RX_FILTER_STATS_EN undefined: no counter registers; both ports SHALL be tied to 0.

Verification
REQ-024 8-word packet, word3=0x0A000001, response hit=1 resp=0x12345 three cycles after the request -> 8 identical words out, tuser=0x12345 on every word, tlast on word 8, fwd_count=1.
REQ-025 Same packet, hit=0 -> no tx beat, drop_count=1, rx_tready=1 two cycles after the response.
REQ-026 3-word packet -> lookup_valid never asserted, drop_count=1, no tx.
REQ-027 70-word packet, MAX_WORDS=64, hit=1 -> all 70 words accepted, no tx, drop_count=1, next 8-word packet forwarded.
REQ-028 tx_tready toggled 1/0 every cycle on a hit packet -> 8 words in order, no duplicates or losses, data stable while stalled.
REQ-029 rst_n pulsed low during FORWARD word 4 -> tx_tvalid=0 immediately, counters 0, following hit packet forwarded intact.

Source files
------------

// File: rtl/rx_conn_filter.sv
// rx_conn_filter: store-and-forward ingress filter that forwards a packet only on a connection lookup hit.
// fwd_count/drop_count registers are built only when RX_FILTER_STATS_EN is defined.
module rx_conn_filter #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WORD   = 3,
  parameter int MAX_WORDS  = 64,
  parameter int RESP_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_rx_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_rx_tdata,
  input  logic                  s_axis_rx_tlast,
  output logic                  s_axis_rx_tready,
  output logic                  m_axis_lookup_valid,
  output logic [31:0]           m_axis_lookup_key,
  input  logic                  m_axis_lookup_ready,
  input  logic                  s_axis_lookup_valid,
  input  logic                  s_axis_lookup_hit,
  input  logic [RESP_WIDTH-1:0] s_axis_lookup_resp,
  output logic                  s_axis_lookup_ready,
  output logic                  m_axis_tx_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tx_tdata,
  output logic                  m_axis_tx_tlast,
  output logic [RESP_WIDTH-1:0] m_axis_tx_tuser,
  input  logic                  m_axis_tx_tready,
  output logic [15:0]           fwd_count,
  output logic [15:0]           drop_count
);
  localparam int AW = $clog2(MAX_WORDS);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] KEY_IDX = PW'(KEY_WORD);
  localparam logic [PW-1:0] MAX_IDX = PW'(MAX_WORDS);
  localparam logic [PW-1:0] ONE     = PW'(1);

  typedef enum logic [2:0] {IDLE, RECV, WAIT_RESP, FORWARD, FLUSH, DISCARD} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  lk_valid_q, lk_valid_d, pend_q, pend_d, got_q, got_d;
  logic                  hit_q, hit_d, junk_q, junk_d;
  logic [31:0]           key_q, key_d;
  logic [RESP_WIDTH-1:0] resp_q, resp_d;
  logic                  tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] mem_q [MAX_WORDS];

  logic rx_acc, wr_ok, wr_en, ovf, full, key_acc, rsp, known, hit_now, pend_after;
  logic tx_load, tx_done, clr;

  assign s_axis_rx_tready    = rst_n && (state_q == IDLE || state_q == RECV || state_q == DISCARD);
  assign rx_acc              = s_axis_rx_tvalid && s_axis_rx_tready;
  assign full                = wr_ptr_q == MAX_IDX;
  assign wr_ok               = rx_acc && state_q != DISCARD;
  assign wr_en               = wr_ok && !full;
  assign ovf                 = wr_ok && full;
  assign key_acc             = wr_en && wr_ptr_q == KEY_IDX;
  // A response counts only against a request that is still awaiting one.
  assign rsp                 = s_axis_lookup_valid && pend_q;
  assign known               = got_q || rsp;
  assign hit_now             = rsp ? s_axis_lookup_hit : hit_q;
  assign pend_after          = (pend_q && !rsp) || key_acc;
  assign tx_load             = state_q == FORWARD && (!tx_valid_q || m_axis_tx_tready) && rd_ptr_q != wr_ptr_q;
  assign tx_done             = state_q == FORWARD && tx_valid_q && m_axis_tx_tready && tx_last_q;
  assign clr                 = state_q == FLUSH || tx_done;

  assign m_axis_lookup_valid = lk_valid_q;
  assign m_axis_lookup_key   = key_q;
  assign s_axis_lookup_ready = 1'b1;
  assign m_axis_tx_tvalid    = tx_valid_q;
  assign m_axis_tx_tdata     = tx_data_q;
  assign m_axis_tx_tlast     = tx_last_q;
  assign m_axis_tx_tuser     = resp_q;

  always_ff @(posedge clk) if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= s_axis_rx_tdata;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_en ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d   = tx_load ? rd_ptr_q + ONE : rd_ptr_q;
    lk_valid_d = key_acc || (lk_valid_q && !m_axis_lookup_ready);
    key_d      = key_acc ? s_axis_rx_tdata[31:0] : key_q;
    pend_d     = pend_after;
    got_d      = known;
    hit_d      = hit_now;
    resp_d     = rsp ? s_axis_lookup_resp : resp_q;
    junk_d     = junk_q || ovf;
    tx_valid_d = tx_load || (tx_valid_q && !m_axis_tx_tready);
    tx_data_d  = tx_load ? mem_q[rd_ptr_q[AW-1:0]] : tx_data_q;
    tx_last_d  = tx_load ? (rd_ptr_q + ONE == wr_ptr_q) : tx_last_q;
    case (state_q)
      IDLE, RECV: if (rx_acc) state_d = !s_axis_rx_tlast ? (ovf ? DISCARD : RECV) :
                                        (known && !ovf) ? (hit_now ? FORWARD : FLUSH) :
                                        pend_after ? WAIT_RESP : FLUSH;
      WAIT_RESP:  if (rsp) state_d = (hit_now && !junk_q) ? FORWARD : FLUSH;
      DISCARD:    if (rx_acc && s_axis_rx_tlast) state_d = pend_after ? WAIT_RESP : FLUSH;
      FORWARD:    if (tx_done) state_d = IDLE;
      FLUSH:      state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      lk_valid_d = 1'b0;
      pend_d     = 1'b0;
      got_d      = 1'b0;
      hit_d      = 1'b0;
      junk_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lk_valid_q <= 1'b0;
      key_q      <= '0;
      pend_q     <= 1'b0;
      got_q      <= 1'b0;
      hit_q      <= 1'b0;
      resp_q     <= '0;
      junk_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lk_valid_q <= lk_valid_d;
      key_q      <= key_d;
      pend_q     <= pend_d;
      got_q      <= got_d;
      hit_q      <= hit_d;
      resp_q     <= resp_d;
      junk_q     <= junk_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
    end
  end

`ifdef RX_FILTER_STATS_EN
  logic [15:0] fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    fwd_cnt_d  = (tx_done && fwd_cnt_q != 16'hFFFF) ? fwd_cnt_q + 16'd1 : fwd_cnt_q;
    drop_cnt_d = (state_q == FLUSH && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign fwd_count  = fwd_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  assign fwd_count  = '0;
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_rx_conn_filter.sv
// tb_rx_conn_filter: directed bench for rx_conn_filter with a delayed-response lookup responder
// and a tx beat recorder that also checks data stability while stalled.
module tb_rx_conn_filter;
`ifdef RX_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk, rst_n;
  logic        s_axis_rx_tvalid, s_axis_rx_tlast, s_axis_rx_tready;
  logic [31:0] s_axis_rx_tdata;
  logic        m_axis_lookup_valid, m_axis_lookup_ready;
  logic [31:0] m_axis_lookup_key;
  logic        s_axis_lookup_valid, s_axis_lookup_hit, s_axis_lookup_ready;
  logic [17:0] s_axis_lookup_resp;
  logic        m_axis_tx_tvalid, m_axis_tx_tlast, m_axis_tx_tready;
  logic [31:0] m_axis_tx_tdata;
  logic [17:0] m_axis_tx_tuser;
  logic [15:0] fwd_count, drop_count;

  rx_conn_filter dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_rx_tvalid(s_axis_rx_tvalid), .s_axis_rx_tdata(s_axis_rx_tdata),
    .s_axis_rx_tlast(s_axis_rx_tlast), .s_axis_rx_tready(s_axis_rx_tready),
    .m_axis_lookup_valid(m_axis_lookup_valid), .m_axis_lookup_key(m_axis_lookup_key),
    .m_axis_lookup_ready(m_axis_lookup_ready),
    .s_axis_lookup_valid(s_axis_lookup_valid), .s_axis_lookup_hit(s_axis_lookup_hit),
    .s_axis_lookup_resp(s_axis_lookup_resp), .s_axis_lookup_ready(s_axis_lookup_ready),
    .m_axis_tx_tvalid(m_axis_tx_tvalid), .m_axis_tx_tdata(m_axis_tx_tdata),
    .m_axis_tx_tlast(m_axis_tx_tlast), .m_axis_tx_tuser(m_axis_tx_tuser),
    .m_axis_tx_tready(m_axis_tx_tready),
    .fwd_count(fwd_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  int          cd = 0, nreq = 0, r_dly = 3, fe = 0, de = 0, st = 0, wc = 0;
  logic        r_hit = 1'b0, tgl = 1'b0;
  logic [17:0] r_val = '0;
  logic [31:0] lkey = '0;
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  logic [17:0] pu = '0;
  logic [31:0] bd[$];
  logic        bl[$];
  logic [17:0] bu[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [7:0] id, input int i, input logic [31:0] key);
    return (i == 3) ? key : {id, 16'h0, 8'(i)};
  endfunction

  // One clock step: record the tx handshake that just completed, check stall stability,
  // run the lookup responder and drive tready for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pv && pr) begin
      bd.push_back(pd);
      bl.push_back(pl);
      bu.push_back(pu);
    end
    if (pv && !pr) begin
      chk("hold_valid", m_axis_tx_tvalid, 1'b1);
      chk("hold_data", m_axis_tx_tdata, pd);
      chk("hold_last", m_axis_tx_tlast, pl);
      chk("hold_user", m_axis_tx_tuser, pu);
    end
    s_axis_lookup_valid = 1'b0;
    if (cd != 0) begin
      cd--;
      if (cd == 0) begin
        s_axis_lookup_valid = 1'b1;
        s_axis_lookup_hit   = r_hit;
        s_axis_lookup_resp  = r_val;
      end
    end else if (m_axis_lookup_valid && m_axis_lookup_ready) begin
      cd   = r_dly;
      nreq++;
      lkey = m_axis_lookup_key;
    end
    m_axis_tx_tready = tgl ? ~m_axis_tx_tready : 1'b1;
    pv = m_axis_tx_tvalid;
    pr = m_axis_tx_tready;
    pd = m_axis_tx_tdata;
    pl = m_axis_tx_tlast;
    pu = m_axis_tx_tuser;
  endtask

  task automatic send(input int n, input logic [31:0] key, input logic [7:0] id, output int stalls);
    logic acc;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      s_axis_rx_tvalid = 1'b1;
      s_axis_rx_tdata  = word(id, i, key);
      s_axis_rx_tlast  = (i == n - 1);
      acc = s_axis_rx_tready;
      tick();
      while (!acc && stalls < 100) begin
        acc = s_axis_rx_tready;
        tick();
        stalls++;
      end
    end
    s_axis_rx_tvalid = 1'b0;
    s_axis_rx_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (!s_axis_rx_tready && c < 500) begin
      tick();
      c++;
    end
    chk("idle_timeout", c < 500, 1'b1);
  endtask

  task automatic chk_pkt(input logic [7:0] id, input logic [31:0] key, input logic [17:0] user, input int n);
    chk("tx_beats", bd.size(), n);
    for (int i = 0; i < bd.size() && i < n; i++) begin
      chk("tx_data", bd[i], word(id, i, key));
      chk("tx_last", bl[i], i == n - 1);
      chk("tx_user", bu[i], user);
    end
    bd.delete();
    bl.delete();
    bu.delete();
  endtask

  task automatic chk_cnt();
    chk("fwd_count", fwd_count, STATS ? fe : 0);
    chk("drop_count", drop_count, STATS ? de : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_axis_rx_tvalid = 1'b0; s_axis_rx_tdata = '0; s_axis_rx_tlast = 1'b0;
    m_axis_lookup_ready = 1'b1; m_axis_tx_tready = 1'b1;
    s_axis_lookup_valid = 1'b0; s_axis_lookup_hit = 1'b0; s_axis_lookup_resp = '0;
    tick();
    tick();
    chk("rst_rx_tready", s_axis_rx_tready, 1'b0);
    chk("rst_lk_valid", m_axis_lookup_valid, 1'b0);
    chk("rst_lk_ready", s_axis_lookup_ready, 1'b1);
    chk("rst_tx_valid", m_axis_tx_tvalid, 1'b0);
    chk_cnt();
    rst_n = 1'b1;
    tick();
    chk("idle_rx_tready", s_axis_rx_tready, 1'b1);

    // hit, response lands with tlast
    r_hit = 1'b1; r_val = 18'h12345; r_dly = 3;
    send(8, 32'h0A000001, 8'h01, st);
    chk("a_stall", st, 0);
    chk("a_tx_early", m_axis_tx_tvalid, 1'b0);
    tick();
    chk("a_tx_lat", m_axis_tx_tvalid, 1'b1);
    chk("a_tx_first", m_axis_tx_tdata, word(8'h01, 0, 32'h0A000001));
    wait_idle();
    fe++;
    chk_pkt(8'h01, 32'h0A000001, 18'h12345, 8);
    chk("a_key", lkey, 32'h0A000001);
    chk("a_nreq", nreq, 1);
    chk_cnt();

    // miss
    r_hit = 1'b0;
    send(8, 32'h0A000001, 8'h02, st);
    chk("b_rx_busy", s_axis_rx_tready, 1'b0);
    tick();
    chk("b_rx_ready", s_axis_rx_tready, 1'b1);
    de++;
    chk_pkt(8'h02, 32'h0A000001, 18'h0, 0);
    chk("b_nreq", nreq, 2);
    chk_cnt();

    // runt: no lookup
    send(3, 32'h0A000001, 8'h03, st);
    wait_idle();
    de++;
    chk_pkt(8'h03, 32'h0A000001, 18'h0, 0);
    chk("c_nreq", nreq, 2);
    chk_cnt();

    // oversize with early hit, then a normal packet
    r_hit = 1'b1; r_dly = 3;
    send(70, 32'h0A0000F0, 8'h04, st);
    chk("d_stall", st, 0);
    wait_idle();
    de++;
    chk_pkt(8'h04, 32'h0A0000F0, 18'h0, 0);
    chk("d_nreq", nreq, 3);
    chk_cnt();
    send(8, 32'h0A000002, 8'h05, st);
    wait_idle();
    fe++;
    chk_pkt(8'h05, 32'h0A000002, 18'h12345, 8);
    chk_cnt();

    // oversize with response arriving long after tlast
    r_dly = 80;
    send(70, 32'h0A0000F1, 8'h06, st);
    tick();
    chk("e_wait_resp", s_axis_rx_tready, 1'b0);
    wait_idle();
    de++;
    chk_pkt(8'h06, 32'h0A0000F1, 18'h0, 0);
    chk("e_nreq", nreq, 5);
    chk_cnt();

    // tready toggling, tlast before response
    r_dly = 6; r_val = 18'h0BEEF; tgl = 1'b1;
    send(8, 32'h0A000003, 8'h07, st);
    wait_idle();
    tgl = 1'b0;
    fe++;
    chk_pkt(8'h07, 32'h0A000003, 18'h0BEEF, 8);
    chk_cnt();

    // stray response with nothing outstanding must not be latched
    s_axis_lookup_valid = 1'b1; s_axis_lookup_hit = 1'b1; s_axis_lookup_resp = 18'h3FFFF;
    tick();
    r_hit = 1'b0; r_dly = 6;
    send(8, 32'h0A000004, 8'h08, st);
    wait_idle();
    de++;
    chk_pkt(8'h08, 32'h0A000004, 18'h0, 0);
    chk_cnt();

    // reset during forward of word 4
    r_hit = 1'b1; r_dly = 3; r_val = 18'h2AAAA;
    send(8, 32'h0A000005, 8'h09, st);
    wc = 0;
    while (!(m_axis_tx_tvalid && m_axis_tx_tdata == 32'h0A000005) && wc < 20) begin
      tick();
      wc++;
    end
    chk("h_reach_w4", m_axis_tx_tvalid && m_axis_tx_tdata == 32'h0A000005, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("h_tx_valid", m_axis_tx_tvalid, 1'b0);
    chk("h_tx_user", m_axis_tx_tuser, 18'h0);
    chk("h_rx_tready", s_axis_rx_tready, 1'b0);
    fe = 0; de = 0;
    chk_cnt();
    pv = 1'b0; cd = 0;
    bd.delete(); bl.delete(); bu.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(8, 32'h0A000006, 8'h0A, st);
    wait_idle();
    fe++;
    chk_pkt(8'h0A, 32'h0A000006, 18'h2AAAA, 8);
    chk("h_key", lkey, 32'h0A000006);
    chk_cnt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
